// File: rtl/i2s_mic_rx.sv
// I2S master receiver for a stereo MEMS mic pair: derives SCK/WS from clk and
// deserialises mic_sd into one signed DATA_W sample per slot with a valid strobe.
module i2s_mic_rx #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 24,
  parameter int SLOT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mic_sd,
  output logic              mic_sck,
  output logic              mic_ws,
  output logic [DATA_W-1:0] mic_data,
  output logic              mic_ch,
  output logic              mic_valid,
  output logic              frame_done,
  output logic              busy
);
  localparam int FRAME_W = 2 * SLOT_W;
  localparam int DIV_BW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FB_BW   = $clog2(FRAME_W);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              r_state, w_next;
  logic [DIV_BW-1:0]   r_div_cnt;
  logic [FB_BW-1:0]    r_fbit, w_fbit_nxt, w_s;
  logic [DATA_W-2:0]   r_shift;
  logic [DATA_W-1:0]   r_data;
  logic                r_sck, r_ws, r_ch, r_valid, r_fd;
  logic                w_tick, w_rise, w_fall, w_wrap, w_cap, w_last;

  assign w_tick     = (r_state != IDLE) && (r_div_cnt == DIV_BW'(CLK_DIV - 1));
  assign w_rise     = w_tick && !r_sck;
  assign w_fall     = w_tick && r_sck;
  assign w_wrap     = w_fall && (r_fbit == FB_BW'(FRAME_W - 1));
  assign w_fbit_nxt = w_wrap ? '0 : r_fbit + 1'b1;
  // r_ws tracks fbit >= SLOT_W, so it selects the slot-relative bit index
  assign w_s        = r_ws ? r_fbit - FB_BW'(SLOT_W) : r_fbit;
  assign w_cap      = w_rise && (w_s != '0) && (w_s <= FB_BW'(DATA_W));
  assign w_last     = w_rise && (w_s == FB_BW'(DATA_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (en) w_next = RUN;
      RUN:     if (!en) w_next = DRAIN;
      DRAIN:   if (en) w_next = RUN;
               else if (w_wrap) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_sck     <= 1'b0;
      r_ws      <= 1'b0;
      r_fbit    <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_ch      <= 1'b0;
      r_valid   <= 1'b0;
      r_fd      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_fd    <= 1'b0;
      if (r_state == IDLE) begin
        r_div_cnt <= '0;
        r_sck     <= 1'b0;
        r_ws      <= 1'b0;
        r_fbit    <= '0;
      end else begin
        r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
        if (w_tick) r_sck <= ~r_sck;
        // WS is re-derived from the new frame position so it only moves on SCK fall
        if (w_fall) begin
          r_fbit <= w_fbit_nxt;
          r_ws   <= (w_fbit_nxt >= FB_BW'(SLOT_W));
        end
        if (w_cap) r_shift <= {r_shift[DATA_W-3:0], mic_sd};
        if (w_last) begin
          r_data  <= {r_shift, mic_sd};
          r_ch    <= r_ws;
          r_valid <= 1'b1;
          r_fd    <= r_ws;
        end
      end
    end
  end

  assign mic_sck    = r_sck;
  assign mic_ws     = r_ws;
  assign mic_data   = r_data;
  assign mic_ch     = r_ch;
  assign mic_valid  = r_valid;
  assign frame_done = r_fd;
  assign busy       = (r_state != IDLE);
endmodule

// File: tb/tb_i2s_mic_rx.sv
// Bench for i2s_mic_rx: a mic model serves random stereo frames, tasks check
// strobes, SCK/WS timing, stop/restart behaviour and async reset.
module tb_i2s_mic_rx;
  localparam int CLK_DIV = 4;
  localparam int DATA_W  = 24;
  localparam int SLOT_W  = 32;
  localparam int FRAME   = 2 * SLOT_W;
  localparam int SPACING = SLOT_W * 2 * CLK_DIV;

  logic clk = 1'b0;
  logic rst, en, mic_sd;
  logic mic_sck, mic_ws, mic_ch, mic_valid, frame_done, busy;
  logic [DATA_W-1:0] mic_data;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  i2s_mic_rx #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .SLOT_W(SLOT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .mic_sd(mic_sd), .mic_sck(mic_sck),
    .mic_ws(mic_ws), .mic_data(mic_data), .mic_ch(mic_ch),
    .mic_valid(mic_valid), .frame_done(frame_done), .busy(busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Mic model: counts SCK falls since the frame start, serves {left,right}
  // from src_arr MSB first after the one-bit delay, and logs expected samples.
  logic [47:0] src_arr [0:255];
  logic [23:0] exp_d [0:1023];
  logic        exp_c [0:1023];
  int mk = 0, ms = 0, fr_idx = 0, wr_idx = 0, ws_bad = 0, v_bad = 0, nstrobe = 0;
  logic prev_sck = 1'b0, prev_ws = 1'b0, prev_v = 1'b0;
  logic [47:0] cur_fr = '0;
  logic [23:0] word;
  int rd_idx = 0;

  function automatic logic junk();
    return ($urandom_range(0, 1) == 1) ? 1'b1 : 1'bx;
  endfunction

  always @(negedge clk) begin
    if (mic_valid) begin
      nstrobe++;
      if (prev_v) v_bad++;
    end
    if (frame_done && !(mic_valid && mic_ch)) v_bad++;
    prev_v = mic_valid;
    if (rst || !busy) begin
      mk = 0;
      mic_sd = junk();
    end else if (prev_sck && !mic_sck) begin
      mk = (mk + 1) % FRAME;
      if (mic_ws !== (mk >= SLOT_W)) ws_bad++;
      if (mk == 1) begin
        cur_fr = src_arr[fr_idx % 256];
        fr_idx++;
        exp_d[wr_idx % 1024] = cur_fr[47:24];
        exp_c[wr_idx % 1024] = 1'b0;
        exp_d[(wr_idx + 1) % 1024] = cur_fr[23:0];
        exp_c[(wr_idx + 1) % 1024] = 1'b1;
        wr_idx += 2;
      end
      word = (mk >= SLOT_W) ? cur_fr[23:0] : cur_fr[47:24];
      ms = mk % SLOT_W;
      mic_sd = (ms >= 1 && ms <= DATA_W) ? word[DATA_W - ms] : junk();
    end else if (mic_ws !== prev_ws) begin
      ws_bad++;
    end
    prev_sck = mic_sck;
    prev_ws  = mic_ws;
  end

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 7;
    if (mic_sck !== 1'b0)    begin failures++; $display("FAIL reset_sck got=%b exp=0", mic_sck); end
    if (mic_ws !== 1'b0)     begin failures++; $display("FAIL reset_ws got=%b exp=0", mic_ws); end
    if (mic_data !== '0)     begin failures++; $display("FAIL reset_data got=%h exp=0", mic_data); end
    if (mic_ch !== 1'b0)     begin failures++; $display("FAIL reset_ch got=%b exp=0", mic_ch); end
    if (mic_valid !== 1'b0)  begin failures++; $display("FAIL reset_valid got=%b exp=0", mic_valid); end
    if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
    if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int n = 0, tprev = 0, ri;
    src_arr[fr_idx % 256]       = {24'hA5A5A5, 24'h5A5A5A};
    src_arr[(fr_idx + 1) % 256] = {24'h7FFFFF, 24'h800001};
    en = 1'b1;
    for (int i = 0; i < 2600 && n < 8; i++) begin
      @(posedge clk); #1;
      if (mic_valid) begin
        ri = rd_idx % 1024;
        checks += 3;
        if (mic_data !== exp_d[ri])  begin failures++; $display("FAIL basic_data n=%0d got=%h exp=%h", n, mic_data, exp_d[ri]); end
        if (mic_ch !== exp_c[ri])    begin failures++; $display("FAIL basic_ch n=%0d got=%b exp=%b", n, mic_ch, exp_c[ri]); end
        if (frame_done !== exp_c[ri]) begin failures++; $display("FAIL basic_fd n=%0d got=%b exp=%b", n, frame_done, exp_c[ri]); end
        if (n > 0) begin
          checks++;
          if (cyc - tprev != SPACING) begin failures++; $display("FAIL basic_spacing n=%0d got=%0d exp=%0d", n, cyc - tprev, SPACING); end
        end
        if (n == 3) begin
          checks++;
          if (mic_data !== 24'h800001) begin failures++; $display("FAIL basic_sign got=%h exp=800001", mic_data); end
        end
        tprev = cyc;
        rd_idx++;
        n++;
      end
    end
    checks++;
    if (n != 8) begin failures++; $display("FAIL basic_count got=%0d exp=8", n); end
  endtask

  task automatic test_sck_waveform();
    int t [0:4];
    int k = 0;
    logic last;
    last = mic_sck;
    for (int i = 0; i < 200 && k < 5; i++) begin
      @(posedge clk); #1;
      if (mic_valid) rd_idx++;
      if (mic_sck !== last) begin t[k] = cyc; k++; end
      last = mic_sck;
    end
    checks++;
    if (k != 5) begin failures++; $display("FAIL sck_edges got=%0d exp=5", k); end
    else for (int j = 1; j < 5; j++) begin
      checks++;
      if (t[j] - t[j-1] != CLK_DIV) begin failures++; $display("FAIL sck_half_period got=%0d exp=%0d", t[j] - t[j-1], CLK_DIV); end
    end
  endtask

  task automatic test_stop_pulse();
    int n = 0, ri;
    en = 1'b0;
    for (int i = 0; i < 1200 && busy; i++) begin
      @(posedge clk); #1;
      if (mic_valid) begin
        ri = rd_idx % 1024;
        checks += 2;
        if (mic_data !== exp_d[ri]) begin failures++; $display("FAIL drain_data got=%h exp=%h", mic_data, exp_d[ri]); end
        if (mic_ch !== exp_c[ri])   begin failures++; $display("FAIL drain_ch got=%b exp=%b", mic_ch, exp_c[ri]); end
        rd_idx++;
      end
    end
    checks += 4;
    if (busy !== 1'b0)       begin failures++; $display("FAIL drain_idle busy=%b exp=0", busy); end
    if (mic_sck !== 1'b0)    begin failures++; $display("FAIL drain_sck got=%b exp=0", mic_sck); end
    if (mic_ws !== 1'b0)     begin failures++; $display("FAIL drain_ws got=%b exp=0", mic_ws); end
    if (rd_idx != wr_idx)    begin failures++; $display("FAIL drain_truncated delivered=%0d exp=%0d", rd_idx, wr_idx); end
    src_arr[fr_idx % 256] = {$urandom_range(0, 24'hFFFFFF), $urandom_range(0, 24'hFFFFFF)};
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    for (int i = 0; i < 1600; i++) begin
      @(posedge clk); #1;
      if (mic_valid) begin
        ri = rd_idx % 1024;
        checks += 3;
        if (mic_data !== exp_d[ri])   begin failures++; $display("FAIL pulse_data n=%0d got=%h exp=%h", n, mic_data, exp_d[ri]); end
        if (mic_ch !== (n == 1))      begin failures++; $display("FAIL pulse_ch n=%0d got=%b exp=%b", n, mic_ch, n == 1); end
        if (frame_done !== (n == 1))  begin failures++; $display("FAIL pulse_fd n=%0d got=%b exp=%b", n, frame_done, n == 1); end
        rd_idx++;
        n++;
      end
    end
    checks += 3;
    if (n != 2)           begin failures++; $display("FAIL pulse_count got=%0d exp=2", n); end
    if (busy !== 1'b0)    begin failures++; $display("FAIL pulse_idle busy=%b exp=0", busy); end
    if (mic_sck !== 1'b0) begin failures++; $display("FAIL pulse_sck got=%b exp=0", mic_sck); end
  endtask

  task automatic test_en_toggle();
    int n = 0, phase = 0, tprev = 0, ri;
    bit gap = 0;
    en = 1'b1;
    for (int i = 0; i < 3000 && n < 6; i++) begin
      @(posedge clk); #1;
      if (phase == 0 && mk == 40) begin en = 1'b0; phase = 1; end
      else if (phase == 1 && mk == 50) begin en = 1'b1; phase = 2; end
      if (!busy) gap = 1;
      if (mic_valid) begin
        ri = rd_idx % 1024;
        checks += 2;
        if (mic_data !== exp_d[ri]) begin failures++; $display("FAIL toggle_data n=%0d got=%h exp=%h", n, mic_data, exp_d[ri]); end
        if (mic_ch !== exp_c[ri])   begin failures++; $display("FAIL toggle_ch n=%0d got=%b exp=%b", n, mic_ch, exp_c[ri]); end
        if (n > 0) begin
          checks++;
          if (cyc - tprev != SPACING) begin failures++; $display("FAIL toggle_spacing n=%0d got=%0d exp=%0d", n, cyc - tprev, SPACING); end
        end
        tprev = cyc;
        rd_idx++;
        n++;
      end
    end
    checks += 3;
    if (n != 6)     begin failures++; $display("FAIL toggle_count got=%0d exp=6", n); end
    if (gap)        begin failures++; $display("FAIL toggle_idle_gap got=1 exp=0"); end
    if (phase != 2) begin failures++; $display("FAIL toggle_phase got=%0d exp=2", phase); end
  endtask

  task automatic test_reset_mid();
    bit hit = 0, got = 0;
    int snap, trel, ri;
    for (int i = 0; i < 1200 && !hit; i++) begin
      @(posedge clk); #1;
      if (mic_valid) rd_idx++;
      if (mk == 10) hit = 1;
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL rstmid_reach got=0 exp=1"); end
    #2 rst = 1'b1;
    snap = nstrobe;
    #1;
    checks += 5;
    if (mic_sck !== 1'b0)    begin failures++; $display("FAIL rstmid_sck got=%b exp=0", mic_sck); end
    if (mic_ws !== 1'b0)     begin failures++; $display("FAIL rstmid_ws got=%b exp=0", mic_ws); end
    if (mic_data !== '0)     begin failures++; $display("FAIL rstmid_data got=%h exp=0", mic_data); end
    if (mic_valid !== 1'b0)  begin failures++; $display("FAIL rstmid_valid got=%b exp=0", mic_valid); end
    if (busy !== 1'b0)       begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    trel = cyc;
    rd_idx = wr_idx;
    checks++;
    if (nstrobe != snap) begin failures++; $display("FAIL rstmid_strobe_in_reset got=%0d exp=%0d", nstrobe, snap); end
    for (int i = 0; i < 400 && !got; i++) begin
      @(posedge clk); #1;
      if (mic_valid) begin
        got = 1;
        ri = rd_idx % 1024;
        checks += 4;
        if (mic_ch !== 1'b0)        begin failures++; $display("FAIL rstmid_ch got=%b exp=0", mic_ch); end
        if (mic_data !== exp_d[ri]) begin failures++; $display("FAIL rstmid_data_after got=%h exp=%h", mic_data, exp_d[ri]); end
        if (frame_done !== 1'b0)    begin failures++; $display("FAIL rstmid_fd got=%b exp=0", frame_done); end
        if (cyc - trel < 190 || cyc - trel > 204)
          begin failures++; $display("FAIL rstmid_latency got=%0d exp=190..204", cyc - trel); end
        rd_idx++;
      end
    end
    checks++;
    if (!got) begin failures++; $display("FAIL rstmid_timeout got=0 exp=1"); end
  endtask

  task automatic test_final();
    en = 1'b0;
    for (int i = 0; i < 1200 && busy; i++) begin
      @(posedge clk); #1;
    end
    checks += 3;
    if (busy !== 1'b0) begin failures++; $display("FAIL final_idle busy=%b exp=0", busy); end
    if (ws_bad != 0)   begin failures++; $display("FAIL ws_timing errors=%0d exp=0", ws_bad); end
    if (v_bad != 0)    begin failures++; $display("FAIL strobe_shape errors=%0d exp=0", v_bad); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      src_arr[i] = {$urandom_range(0, 24'hFFFFFF), $urandom_range(0, 24'hFFFFFF)};
    test_reset();
    test_basic();
    test_sck_waveform();
    test_stop_pulse();
    test_en_toggle();
    test_reset_mid();
    test_final();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
